// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared state encoding and width helpers for the counting sorter
package sort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_COUNT  = 3'd2,
        ST_PREFIX = 3'd3,
        ST_PLACE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int hist_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // One pass counter walks both the key list and the histogram.
    function automatic int pass_cnt_width(input int n, input int w);
        return (w > idx_width(n)) ? w : idx_width(n);
    endfunction

endpackage

// File: rtl/sort_hist_mem.sv
// rtl/sort_hist_mem.sv - histogram RAM, combinational read and synchronous write
module sort_hist_mem #(
    parameter int AW = 8,
    parameter int DW = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/counting_sort_param.sv
// rtl/counting_sort_param.sv - stable counting sort of N W-bit keys with index permutation
module counting_sort_param
    import sort_pkg::*;
#(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int IW = idx_width(N),
    parameter int CW = hist_cnt_width(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            desc_i,
    input  logic [N*W-1:0]  data_i,
    output logic            busy_o,
    output logic            valid_o,
    input  logic            ack_i,
    output logic [N*W-1:0]  data_o,
    output logic [N*IW-1:0] idx_o
);

    localparam int PCW = pass_cnt_width(N, W);
    localparam logic [PCW-1:0] HIST_LAST = PCW'((1 << W) - 1);
    localparam logic [PCW-1:0] KEY_LAST  = PCW'(N - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(N - 1);

    state_t          state;
    logic [PCW-1:0]  pass_cnt;
    logic [CW-1:0]   run_sum;
    logic [N*W-1:0]  key_buf;
    logic            desc_q;

    logic            mem_we;
    logic [W-1:0]    mem_addr;
    logic [CW-1:0]   mem_wdata;
    logic [CW-1:0]   mem_rdata;

    logic [IW-1:0]   place_i;
    logic [IW-1:0]   key_sel;
    logic [W-1:0]    key_at;
    logic [IW-1:0]   dest_p;

    // Descending walks keys backwards and mirrors the slot, which keeps ties in index order.
    assign place_i = desc_q ? (IDX_LAST - pass_cnt[IW-1:0]) : pass_cnt[IW-1:0];
    assign key_sel = (state == ST_PLACE) ? place_i : pass_cnt[IW-1:0];
    assign key_at  = key_buf[int'(key_sel)*W +: W];
    assign dest_p  = desc_q ? (IDX_LAST - mem_rdata[IW-1:0]) : mem_rdata[IW-1:0];

    sort_hist_mem #(
        .AW (W),
        .DW (CW)
    ) u_hist (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = pass_cnt[W-1:0];
            end
            ST_COUNT, ST_PLACE: begin
                mem_we    = 1'b1;
                mem_addr  = key_at;
                mem_wdata = mem_rdata + CW'(1);
            end
            ST_PREFIX: begin
                mem_we    = 1'b1;
                mem_addr  = pass_cnt[W-1:0];
                mem_wdata = run_sum;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            pass_cnt <= '0;
            run_sum  <= '0;
            key_buf  <= '0;
            desc_q   <= 1'b0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            idx_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        key_buf  <= data_i;
                        desc_q   <= desc_i;
                        pass_cnt <= '0;
                        busy_o   <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (pass_cnt == HIST_LAST) begin
                        pass_cnt <= '0;
                        state    <= ST_COUNT;
                    end else begin
                        pass_cnt <= pass_cnt + PCW'(1);
                    end
                end
                ST_COUNT: begin
                    if (pass_cnt == KEY_LAST) begin
                        pass_cnt <= '0;
                        run_sum  <= '0;
                        state    <= ST_PREFIX;
                    end else begin
                        pass_cnt <= pass_cnt + PCW'(1);
                    end
                end
                ST_PREFIX: begin
                    run_sum <= run_sum + mem_rdata;
                    if (pass_cnt == HIST_LAST) begin
                        pass_cnt <= '0;
                        state    <= ST_PLACE;
                    end else begin
                        pass_cnt <= pass_cnt + PCW'(1);
                    end
                end
                ST_PLACE: begin
                    data_o[int'(dest_p)*W +: W]  <= key_at;
                    idx_o[int'(dest_p)*IW +: IW] <= place_i;
                    if (pass_cnt == KEY_LAST) begin
                        pass_cnt <= '0;
                        valid_o  <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        pass_cnt <= pass_cnt + PCW'(1);
                    end
                end
                ST_DONE: begin
                    if (ack_i) begin
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counting_sort_param.sv
// tb/tb_counting_sort_param.sv - scoreboard bench for counting_sort_param
module tb_counting_sort_param;

    typedef struct {
        logic [127:0] data;
        logic [63:0]  idx;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         desc = 1'b0;
    logic         ack = 1'b0;
    logic [127:0] din = '0;
    logic         busy, valid;
    logic [127:0] dout;
    logic [63:0]  iout;

    logic         s_start = 1'b0;
    logic [11:0]  s_din = '0;
    logic         s_busy, s_valid;
    logic [11:0]  s_dout;
    logic [7:0]   s_iout;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    longint accept_time = 0;
    logic v_prev = 1'b0;

    always #5 clk = ~clk;

    counting_sort_param dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .desc_i(desc), .data_i(din),
        .busy_o(busy), .valid_o(valid), .ack_i(ack), .data_o(dout), .idx_o(iout)
    );

    counting_sort_param #(.N(4), .W(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .desc_i(1'b0), .data_i(s_din),
        .busy_o(s_busy), .valid_o(s_valid), .ack_i(1'b0), .data_o(s_dout), .idx_o(s_iout)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_keys(input int k[16]);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = k[i][7:0];
        return r;
    endfunction

    function automatic logic [63:0] pack_idx(input int k[16]);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = k[i][3:0];
        return r;
    endfunction

    // Monitor: every rising valid_o is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (valid && !v_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_o", dout, e.data);
                chk("idx_o", {64'd0, iout}, {64'd0, e.idx});
                chk("latency", 128'((($time - 5) - accept_time) / 10), 128'(e.lat));
            end
        end
        v_prev = valid;
    end

    task automatic start_only(input int keys[16], input logic d);
        din   = pack_keys(keys);
        desc  = d;
        start = 1'b1;
        @(posedge clk);
        accept_time = $time;
        #1 start = 1'b0;
    endtask

    task automatic issue(input int keys[16], input logic d, input int ek[16], input int ei[16]);
        exp_t e;
        e.data = pack_keys(ek);
        e.idx  = pack_idx(ei);
        e.lat  = 544;
        sb.push_back(e);
        start_only(keys, d);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (valid) break;
            n++;
        end
        if (n >= 2000) chk("valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
    endtask

    initial begin
        int k_rev[16], e_id[16], i_rev[16];
        int k_stb[16], e_stb_a[16], i_stb_a[16], e_stb_d[16], i_stb_d[16];
        int k_ff[16], e_ff[16], i_ff[16];
        int k_aa[16];
        int n;

        for (int i = 0; i < 16; i++) begin
            k_rev[i] = 15 - i;
            e_id[i]  = i;
            i_rev[i] = 15 - i;
            k_aa[i]  = 'hAA;
        end
        k_stb   = '{7,3,7,3,0,7,0,3,7,3,7,3,0,7,0,3};
        e_stb_a = '{0,0,0,0,3,3,3,3,3,3,7,7,7,7,7,7};
        i_stb_a = '{4,6,12,14,1,3,7,9,11,15,0,2,5,8,10,13};
        e_stb_d = '{7,7,7,7,7,7,3,3,3,3,3,3,0,0,0,0};
        i_stb_d = '{0,2,5,8,10,13,1,3,7,9,11,15,4,6,12,14};
        k_ff    = '{0,0,0,0,0,255,0,0,0,255,0,0,0,0,0,0};
        e_ff    = '{255,255,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        i_ff    = '{5,9,0,1,2,3,4,6,7,8,10,11,12,13,14,15};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_valid", 128'(valid), 128'd0);
        chk("reset_data", dout, 128'd0);
        chk("reset_idx", {64'd0, iout}, 128'd0);

        @(posedge clk);
        #1;
        issue(k_rev, 1'b0, e_id, i_rev);
        wait_valid();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 start = c[0];
            din = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("hold_valid", 128'(valid && busy), 128'd1);
            chk("hold_data", dout, pack_keys(e_id));
            chk("hold_idx", {64'd0, iout}, {64'd0, pack_idx(i_rev)});
        end
        @(posedge clk);
        #1 start = 1'b1;
        ack = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ack = 1'b0;
        @(negedge clk);
        chk("ack_busy", 128'(busy), 128'd0);
        chk("ack_valid", 128'(valid), 128'd0);
        chk("retain_data", dout, pack_keys(e_id));
        @(posedge clk);
        #1;
        issue(k_stb, 1'b0, e_stb_a, i_stb_a);
        chk("fresh_start_busy", 128'(busy), 128'd1);
        wait_valid();
        do_ack();

        issue(k_stb, 1'b1, e_stb_d, i_stb_d);
        wait_valid();
        do_ack();

        issue(k_ff, 1'b1, e_ff, i_ff);
        wait_valid();
        do_ack();

        start_only(k_rev, 1'b0);
        repeat (256 + 16 + 20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midreset_busy", 128'(busy), 128'd0);
        chk("midreset_valid", 128'(valid), 128'd0);
        chk("midreset_data", dout, 128'd0);
        chk("midreset_idx", {64'd0, iout}, 128'd0);
        @(posedge clk);
        #1;
        issue(k_aa, 1'b0, k_aa, e_id);
        wait_valid();
        do_ack();

        s_din   = {3'd2, 3'd1, 3'd5, 3'd5};
        s_din   = {3'd2, 3'd5, 3'd1, 3'd5};
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (s_valid) break;
        end
        chk("sweep_latency", 128'(n), 128'd24);
        chk("sweep_data", 128'(s_dout), 128'({3'd5, 3'd5, 3'd2, 3'd1}));
        chk("sweep_idx", 128'(s_iout), 128'({2'd2, 2'd0, 2'd3, 2'd1}));

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/counting_sort_param.md
Name: counting_sort_param

Overview:
- Parametrised counting-sort engine that sorts N unsigned W-bit keys in one batch.
- Ascending or descending order is selectable per batch, and equal keys keep their input order (stable sort).
- Alongside the sorted keys it returns the original-index permutation, so downstream blocks can reorder payloads.
- Sits behind a start/busy/valid/ack handshake and replaces the fixed 16x8 sorter in the sort datapath.

Parameters:
- N, 16, number of keys per batch (power of two, 2..256).
- W, 8, key width in bits (1..10); histogram depth is 2^W.
- IW, $clog2(N), width of one index field (derived).
- CW, $clog2(N+1), width of one histogram counter (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- start_i  in  1  request a sort; accepted only in IDLE.
- desc_i  in  1  order select, sampled with start_i; 0 = ascending, 1 = descending.
- data_i  in  N*W  input keys; key k at bits [k*W +: W].
- busy_o  out  1  high in every state except IDLE.
- valid_o  out  1  high in DONE; result is stable while high.
- ack_i  in  1  consumer accepts the result; honoured only when valid_o=1.
- data_o  out  N*W  sorted keys; position p at [p*W +: W].
- idx_o  out  N*IW  idx_o field p = original index of the key at data_o position p.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst_i=1 at an edge) forces state IDLE. Reset values: busy_o=0, valid_o=0, data_o=0, idx_o=0, all pass counters=0.
- Reset wins over every other event, including mid-pass; any partial result is discarded.
- Histogram memory (2^W x CW) is not reset; the CLEAR pass initialises it, so it may map to RAM.
- States: IDLE, CLEAR, COUNT, PREFIX, PLACE, DONE.
- IDLE -> CLEAR when start_i=1. On that edge capture data_i into the input buffer and desc_i into the mode register.
- CLEAR: 2^W cycles; write hist[v]=0 for v = 0..2^W-1, then go to COUNT.
- COUNT: N cycles; for i = 0..N-1, hist[key[i]]++, then go to PREFIX.
- PREFIX: 2^W cycles; convert hist to an exclusive prefix sum, hist[v] = sum of hist[u] for u<v.
  - Use a CW-bit running-sum register.
  - The running sum can reach N; hist[2^W-1] never exceeds N-1.
  - Then go to PLACE.
- PLACE: N cycles; visit j = 0..N-1.
  - Ascending: i = j. Descending: i = N-1-j.
  - Compute c = hist[key[i]], then write hist[key[i]] = c+1.
  - Destination p = c (ascending) or N-1-c (descending).
  - Write out_key[p] = key[i] and out_idx[p] = i.
  - Then go to DONE.
- Stability: equal keys appear in data_o in increasing original index for both orders.
- DONE: valid_o=1; data_o and idx_o hold. ack_i=1 -> IDLE, with valid_o low the next cycle.
- start_i in the same cycle as ack_i is ignored; a new start is taken in IDLE only.
- start_i while busy_o=1 is ignored; no queuing.
- data_o and idx_o keep the last result after DONE -> IDLE until the next PLACE overwrites them.
- Latency: valid_o rises exactly 2*2^W + 2N rising edges after the accepting edge (544 for the defaults).
- No back-to-back overlap: throughput is one batch per latency plus ack.
- Arithmetic: unsigned keys throughout. All pass counters wrap-free; each pass ends on terminal count (N-1 or 2^W-1).

Decomposition:
- Shared package sort_pkg holds the state encodings (IDLE=0..DONE=5, 3 bits) and clog2-derived width helpers.
- One natural sub-module: sort_hist_mem, a 2^W x CW single-write-port memory with combinational read and synchronous write.
  - It serves every pass, since each pass issues at most one read-modify-write per cycle.
- Input/output buffers and the FSM stay in the top.

Test Plan:
- Defaults, ascending, data_i keys k=0..15 = {15,14,...,0} -> after 544 edges valid_o=1; data_o position p = p; idx_o position p = 15-p.
- Stability: keys = {7,3,7,3,0,7,0,3,...} (pattern repeated), desc_i=0 -> 0s first, then 3s, then 7s. Within each key, idx_o fields strictly increase.
- Descending: keys all 0x00 except key5=0xFF and key9=0xFF, desc_i=1 -> data_o p0,p1 = 0xFF with idx 5,9; p2..p15 = 0 with idx 0,1,2,3,4,6,7,8,10..15.
- Handshake: hold ack_i=0 for 20 cycles after valid_o -> outputs unchanged and start_i pulses ignored. ack_i=1 -> IDLE; a fresh start is accepted the following cycle.
- Reset mid-PREFIX (rst_i=1 one cycle) -> next cycle busy_o=0, valid_o=0, data_o=0. A following sort of all-0xAA keys gives all 0xAA with idx_o = 0..15.
- Parameter sweep N=4, W=3, keys {5,1,5,2}, asc -> data_o {1,2,5,5}, idx_o {1,3,0,2}, latency 24 edges.
